// File: rtl/timer_irq_ctrl.sv
// rtl/timer_irq_ctrl.sv - memory-mapped interval timer with pending/service interrupt sequencer
//
// Purpose:
//   Counts cycles in TL, reloads TL from TH on overflow, and raises a single
//   interrupt request per overflow. The request is tracked through pending,
//   kernel service and software acknowledge (ST clear), and is masked while
//   the instruction in decode runs in kernel mode.
//
// Register map (byte offsets from BASE_ADDR, addr[1:0] ignored):
//   +0 TH   reload value, R/W
//   +4 TL   counter, R/W
//   +8 TCON {OV, ST, IE, EN}, R/W, bits [31:4] read 0
//   +C CYC  free-running cycle counter, read-only
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   rd, wr     bus read / write strobes
//   addr       bus byte address
//   wdata      bus write data
//   rdata      bus read data, combinational, 0 unless a mapped read
//   pc31       kernel-mode bit of the instruction in decode
//   irq_taken  pipeline redirected to the interrupt vector this cycle
//   irq        interrupt request to the control decoder

module timer_irq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        pc31,
  input  logic        irq_taken,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SERV = 2'd2
  } state_t;

  localparam logic [29:0] WORD_TH   = BASE_ADDR[31:2];
  localparam logic [29:0] WORD_TL   = BASE_ADDR[31:2] + 30'd1;
  localparam logic [29:0] WORD_TCON = BASE_ADDR[31:2] + 30'd2;
  localparam logic [29:0] WORD_CYC  = BASE_ADDR[31:2] + 30'd3;

  localparam int EN = 0;
  localparam int IE = 1;
  localparam int ST = 2;
  localparam int OV = 3;

  logic [31:0] th;
  logic [31:0] tl;
  logic [3:0]  tcon;
  logic [31:0] cyc;
  state_t      state;

  logic [31:0] th_next;
  logic [31:0] tl_next;
  logic [3:0]  tcon_next;
  state_t      state_next;

  logic sel_th;
  logic sel_tl;
  logic sel_tcon;
  logic sel_cyc;
  logic tcon_wr;
  logic ovf;
  logic hw_set;
  logic sw_clear_st;

  // Byte-lane bits are not decoded.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr[1:0];

  assign sel_th   = (addr[31:2] == WORD_TH);
  assign sel_tl   = (addr[31:2] == WORD_TL);
  assign sel_tcon = (addr[31:2] == WORD_TCON);
  assign sel_cyc  = (addr[31:2] == WORD_CYC);

  assign tcon_wr  = wr & sel_tcon;

  // Overflow is the edge where an enabled counter sits at all-ones.
  assign ovf    = tcon[EN] & (tl == 32'hFFFF_FFFF);
  assign hw_set = ovf & tcon[IE];

  // Software attempted to clear ST this cycle (it may still lose to hw_set).
  assign sw_clear_st = tcon_wr & ~wdata[ST];

  always_comb begin
    th_next = th;
    if (wr && sel_th) begin
      th_next = wdata;
    end
  end

  // A software write to TL takes priority over both reload and increment.
  always_comb begin
    tl_next = tl;
    if (wr && sel_tl) begin
      tl_next = wdata;
    end else if (ovf) begin
      tl_next = th;
    end else if (tcon[EN]) begin
      tl_next = tl + 32'd1;
    end
  end

  // Software value first, then hardware sets are OR-ed on top so a set
  // always beats a simultaneous software clear. OV flags an overflow that
  // arrives while the previous one is still being serviced.
  always_comb begin
    tcon_next = tcon;
    if (tcon_wr) begin
      tcon_next = wdata[3:0];
    end
    if (hw_set) begin
      tcon_next[ST] = 1'b1;
      if (state == SERV) begin
        tcon_next[OV] = 1'b1;
      end
    end
  end

  // The FSM looks at ST as it will be after this edge, so a cleared-and-reset
  // ST in SERV means a fresh overflow needs a fresh request.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (tcon_next[ST]) begin
          state_next = PEND;
        end
      end
      PEND: begin
        if (!tcon_next[ST]) begin
          state_next = IDLE;
        end else if (irq_taken) begin
          state_next = SERV;
        end
      end
      SERV: begin
        if (!tcon_next[ST]) begin
          state_next = IDLE;
        end else if (sw_clear_st && hw_set) begin
          state_next = PEND;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th    <= 32'd0;
      tl    <= 32'd0;
      tcon  <= 4'd0;
      cyc   <= 32'd0;
      state <= IDLE;
    end else begin
      th    <= th_next;
      tl    <= tl_next;
      tcon  <= tcon_next;
      cyc   <= cyc + 32'd1;
      state <= state_next;
    end
  end

  // Purely combinational so the request drops immediately on reset or when
  // the decode stage enters kernel mode.
  assign irq = (state == PEND) & tcon[IE] & ~pc31;

  always_comb begin
    rdata = 32'd0;
    if (rd) begin
      if (sel_th) begin
        rdata = th;
      end else if (sel_tl) begin
        rdata = tl;
      end else if (sel_tcon) begin
        rdata = {28'd0, tcon};
      end else if (sel_cyc) begin
        rdata = cyc;
      end
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb/tb_timer_irq_ctrl.sv - directed self-checking bench for timer_irq_ctrl

module tb_timer_irq_ctrl;

  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [31:0] A_TH   = BASE;
  localparam logic [31:0] A_TL   = BASE + 32'd4;
  localparam logic [31:0] A_TCON = BASE + 32'd8;
  localparam logic [31:0] A_CYC  = BASE + 32'd12;
  localparam logic [31:0] A_BAD  = BASE + 32'd16;

  logic        clk;
  logic        reset;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        pc31;
  logic        irq_taken;
  logic        irq;

  int total;
  int bad;

  logic [31:0] cyc_model;
  logic [31:0] d;

  timer_irq_ctrl #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd        (rd),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .pc31      (pc31),
    .irq_taken (irq_taken),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc_model <= 32'd0;
    else       cyc_model <= cyc_model + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] v);
    addr  = a;
    wdata = v;
    wr    = 1'b1;
    tick();
    wr    = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    rd   = 1'b1;
    #1;
    v    = rdata;
    rd   = 1'b0;
  endtask

  task automatic pulse_taken();
    irq_taken = 1'b1;
    tick();
    irq_taken = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    rd = 1'b0;
    wr = 1'b0;
    addr = 32'd0;
    wdata = 32'd0;
    pc31 = 1'b0;
    irq_taken = 1'b0;

    #2;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rdata_idle", rdata, 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // reset / readback
    bus_wr(A_TH, 32'h1234_5678);
    bus_wr(A_TCON, 32'd0);
    bus_rd(A_TH, d);   check("rb_th", d, 32'h1234_5678);
    bus_rd(A_TL, d);   check("rb_tl", d, 32'd0);
    bus_rd(A_TCON, d); check("rb_tcon", d, 32'd0);
    check("rb_irq", {31'd0, irq}, 32'd0);
    bus_rd(A_CYC, d);  check("rb_cyc", d, cyc_model);
    bus_wr(A_CYC, 32'hDEAD_0000);
    bus_rd(A_CYC, d);  check("cyc_ro", d, cyc_model);
    bus_wr(A_BAD, 32'hFFFF_FFFF);
    bus_rd(A_BAD, d);  check("unmapped_rd", d, 32'd0);
    bus_rd(A_TH, d);   check("unmapped_wr_th", d, 32'h1234_5678);

    // periodic overflow
    bus_wr(A_TH, 32'hFFFF_FFFC);
    bus_wr(A_TL, 32'hFFFF_FFFC);
    bus_wr(A_TCON, 32'd3);
    bus_rd(A_TL, d); check("per_tl_fc", d, 32'hFFFF_FFFC);
    tick();
    bus_rd(A_TL, d); check("per_tl_fd", d, 32'hFFFF_FFFD);
    tick();
    bus_rd(A_TL, d); check("per_tl_fe", d, 32'hFFFF_FFFE);
    tick();
    bus_rd(A_TL, d); check("per_tl_ff", d, 32'hFFFF_FFFF);
    check("per_irq_pre", {31'd0, irq}, 32'd0);
    tick();
    bus_rd(A_TL, d);   check("per_tl_reload", d, 32'hFFFF_FFFC);
    bus_rd(A_TCON, d); check("per_tcon_st", d, 32'h7);
    check("per_irq", {31'd0, irq}, 32'd1);

    // kernel masking (TL = FC here, keeps counting)
    pc31 = 1'b1;
    #1; check("km_irq0", {31'd0, irq}, 32'd0);
    tick(); check("km_irq1", {31'd0, irq}, 32'd0);
    tick(); check("km_irq2", {31'd0, irq}, 32'd0);
    tick();
    pc31 = 1'b0;
    #1; check("km_irq_back", {31'd0, irq}, 32'd1);

    // service handshake; TL = FF so the taken edge is also an overflow
    pulse_taken();
    check("sv_irq_low", {31'd0, irq}, 32'd0);
    bus_rd(A_TCON, d); check("sv_tcon_no_ov", d, 32'h7);
    tick(); tick(); tick();
    check("sv_irq_ff", {31'd0, irq}, 32'd0);
    tick();
    bus_rd(A_TCON, d); check("sv_tcon_ov", d, 32'hF);
    check("sv_irq_ov", {31'd0, irq}, 32'd0);
    bus_wr(A_TCON, 32'd3);
    bus_rd(A_TCON, d); check("sv_tcon_clr", d, 32'h3);
    check("sv_irq_idle", {31'd0, irq}, 32'd0);
    pulse_taken();
    check("taken_idle_ignored", {31'd0, irq}, 32'd0);

    // simultaneous clear and overflow; TL = FE here
    tick();
    tick();
    check("sc_irq_pend", {31'd0, irq}, 32'd1);
    pulse_taken();
    check("sc_irq_serv", {31'd0, irq}, 32'd0);
    tick();
    tick();
    bus_rd(A_TL, d); check("sc_tl_ff", d, 32'hFFFF_FFFF);
    bus_wr(A_TCON, 32'd3);
    bus_rd(A_TCON, d); check("sc_tcon", d, 32'hF);
    check("sc_irq", {31'd0, irq}, 32'd1);

    // async reset while irq is high
    #2;
    reset = 1'b1;
    #1;
    check("ar_irq_drop", {31'd0, irq}, 32'd0);
    tick();
    reset = 1'b0;
    bus_rd(A_TCON, d); check("ar_tcon", d, 32'd0);
    bus_rd(A_TL, d);   check("ar_tl", d, 32'd0);
    bus_rd(A_TH, d);   check("ar_th", d, 32'd0);

    // overflow with IE=0 reloads only; software TL write beats reload
    bus_wr(A_TH, 32'd5);
    bus_wr(A_TL, 32'hFFFF_FFFF);
    bus_wr(A_TCON, 32'd1);
    tick();
    bus_rd(A_TL, d);   check("noie_tl", d, 32'd5);
    bus_rd(A_TCON, d); check("noie_tcon", d, 32'd1);
    check("noie_irq", {31'd0, irq}, 32'd0);
    bus_wr(A_TL, 32'hFFFF_FFFF);
    bus_wr(A_TL, 32'h77);
    bus_rd(A_TL, d);   check("tl_wr_wins", d, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
